cdb_arbiter: RTL and testbench

Completion-side producer of the common data bus. Collects finished results from up to NUM_FU functional units and holds each in a one-entry buffer. Grants one buffered result per cycle round-robin and drives a registered CDB packet (tag, value, take_branch) to the ROB, reservation stations and map table. Honors the pipeline stall and the ROB squash.

---
 rtl/sys_defs.sv | 47 ++++
 rtl/cdb_arbiter_rr.sv | 29 ++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Core-wide sizing defines and the packet layouts shared between the
// functional units, the CDB producer and its consumers.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_LEN
`define ROB_LEN 16
`endif
`ifndef NUM_FU
`define NUM_FU 4
`endif

package sys_defs;

    localparam int ROB_TAG_W = $clog2(`ROB_LEN);

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic                 valid;
    } REG_TAG;

    // Broadcast layout consumed by the ROB, reservation stations and map table.
    typedef struct packed {
        logic              no_output;
        REG_TAG            reg_tag;
        logic [`XLEN-1:0]  reg_value;
        logic              take_branch;
    } CDB_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic                 has_dest;
        logic [`XLEN-1:0]     value;
        logic                 take_branch;
    } FU2CDB_PACKET;

    function automatic int rr_next(int idx, int n);
        return (idx + 1) % n;
    endfunction

endpackage

`endif

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first request at or after rr_ptr,
// wrapping modulo N, returned one-hot.
module rr_arbiter
    import sys_defs::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-side CDB producer: one-entry result buffer per FU, round-robin
// grant of one buffer per cycle, registered broadcast honoring stall/squash.
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int NUM_FU = `NUM_FU,
    parameter int TAG_W  = $clog2(`ROB_LEN),
    parameter int XLEN   = `XLEN
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         squash,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag,
    input  logic [NUM_FU-1:0]            fu_has_dest,
    input  logic [NUM_FU-1:0][XLEN-1:0]  fu_value,
    input  logic [NUM_FU-1:0]            fu_take_branch,
    output logic [NUM_FU-1:0]            fu_ready,
    output logic                         cdb_no_output,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic                         cdb_tag_valid,
    output logic [XLEN-1:0]              cdb_value,
    output logic                         cdb_take_branch
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             has_dest;
        logic [XLEN-1:0]  value;
        logic             take_branch;
    } entry_t;

    logic [NUM_FU-1:0] held, req, grant, xfer;
    entry_t [NUM_FU-1:0] buf_q;
    logic [PTR_W-1:0] rr_ptr, grant_idx;
    logic             fire;
    entry_t           sel;

    // Gating the request vector keeps grant, pointer and buffer clears consistent.
    assign req = (stall || squash) ? '0 : held;

    rr_arbiter #(.N(NUM_FU), .PTR_W(PTR_W)) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign fu_ready = ~held | (grant & {NUM_FU{~stall}});
    assign xfer     = fu_valid & fu_ready;
    assign fire     = |grant;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_FU; i++)
            if (grant[i]) grant_idx = PTR_W'(i);
    end

    assign sel = buf_q[grant_idx];

    // A refill wins over the grant clear: the old entry is already on its way out.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset || squash)
                held[i] <= 1'b0;
            else if (xfer[i])
                held[i] <= 1'b1;
            else if (grant[i])
                held[i] <= 1'b0;
            if (xfer[i] && !squash)
                buf_q[i] <= '{tag: fu_tag[i], has_dest: fu_has_dest[i],
                              value: fu_value[i], take_branch: fu_take_branch[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (fire)
            rr_ptr <= PTR_W'(rr_next(int'(grant_idx), NUM_FU));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_no_output   <= 1'b1;
            cdb_tag         <= '0;
            cdb_tag_valid   <= 1'b0;
            cdb_value       <= '0;
            cdb_take_branch <= 1'b0;
        end else if (squash) begin
            cdb_no_output   <= 1'b1;
            cdb_tag_valid   <= 1'b0;
            cdb_take_branch <= 1'b0;
        end else if (!stall) begin
            cdb_no_output <= ~fire;
            if (fire) begin
                cdb_tag         <= sel.tag;
                cdb_tag_valid   <= sel.has_dest;
                cdb_value       <= sel.value;
                cdb_take_branch <= sel.take_branch;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle vector table plus hand sequences; every
// broadcast is checked against a queue of expected results in arrival order.
module tb_cdb_arbiter;
    import sys_defs::*;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int XW = 32;

    logic clock = 1'b0;
    logic reset, stall, squash;
    logic [N-1:0]         fu_valid, fu_has_dest, fu_take_branch, fu_ready;
    logic [N-1:0][TW-1:0] fu_tag;
    logic [N-1:0][XW-1:0] fu_value;
    logic                 cdb_no_output, cdb_tag_valid, cdb_take_branch;
    logic [TW-1:0]        cdb_tag;
    logic [XW-1:0]        cdb_value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [XW-1:0] value;
        logic          tv;
        logic          tb;
    } bc_t;
    bc_t exp_q[$];

    typedef struct {
        logic        st, sq, pu;
        logic [3:0]  val;
        logic [15:0] tags;
        int          start;
        logic [3:0]  rdy;
        logic        no;
        logic [3:0]  et;
    } vec_t;
    vec_t vecs[31];

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .XLEN(XW)) dut (
        .clock(clock), .reset(reset), .stall(stall), .squash(squash),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_has_dest(fu_has_dest),
        .fu_value(fu_value), .fu_take_branch(fu_take_branch), .fu_ready(fu_ready),
        .cdb_no_output(cdb_no_output), .cdb_tag(cdb_tag), .cdb_tag_valid(cdb_tag_valid),
        .cdb_value(cdb_value), .cdb_take_branch(cdb_take_branch)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val_of(int n, int i, logic [3:0] t);
        return 32'hC0DE_0000 | 32'(n << 8) | 32'(i << 4) | {28'h0, t};
    endfunction

    task automatic drive(int n, logic st, logic sq, logic pu, logic [3:0] val,
                         logic [15:0] tags, int start);
        stall    = st;
        squash   = sq;
        fu_valid = val;
        for (int i = 0; i < N; i++) begin
            fu_tag[i]         = tags[i*4 +: 4];
            fu_value[i]       = val_of(n, i, tags[i*4 +: 4]);
            fu_has_dest[i]    = ~tags[i*4+3];
            fu_take_branch[i] = tags[i*4+2];
        end
        if (pu && !sq)
            for (int k = 0; k < N; k++) begin
                int i;
                i = (start + k) % N;
                if (val[i]) exp_q.push_back('{fu_tag[i], fu_value[i], fu_has_dest[i], fu_take_branch[i]});
            end
    endtask

    // Scoreboard side: a fresh broadcast exists only after an edge without stall/squash/reset.
    logic m_st, m_sq, m_rst;
    bc_t  m_e;
    always @(posedge clock) begin
        m_st  = stall;
        m_sq  = squash;
        m_rst = reset;
        #3;
        if (!m_rst && !m_sq && !m_st && !cdb_no_output) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_broadcast: got tag %h expected none", cdb_tag);
            end else begin
                m_e = exp_q.pop_front();
                chk("bc_tag", 32'(cdb_tag), 32'(m_e.tag));
                chk("bc_value", cdb_value, m_e.value);
                chk("bc_tag_valid", 32'(cdb_tag_valid), 32'(m_e.tv));
                chk("bc_take_branch", 32'(cdb_take_branch), 32'(m_e.tb));
            end
        end
    end

    task automatic idle(int n);
        drive(n, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 0);
    endtask

    initial begin
        //            st    sq    pu    valid    tags     start ready    no    etag
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b1, 4'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 16'h0030, 0, 4'b1111, 1'b1, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b1, 4'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'h3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b1000, 16'h7000, 0, 4'b1111, 1'b1, 4'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b1, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'h7};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 16'h3210, 0, 4'b1111, 1'b1, 4'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b0001, 1'b1, 4'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b0011, 1'b0, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b0111, 1'b0, 4'h1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'h2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'b0100, 16'h0900, 0, 4'b1111, 1'b0, 4'h3};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b1, 4'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'b1001, 16'hB00A, 3, 4'b1111, 1'b0, 4'h9};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1110, 1'b1, 4'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'hB};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 4'b0011, 16'h00DC, 1, 4'b1111, 1'b0, 4'hA};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1110, 1'b1, 4'h0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'hD};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'hC};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 4'b0110, 16'h0EF0, 1, 4'b1111, 1'b1, 4'h0};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1011, 1'b1, 4'h0};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 4'b0001, 16'h0004, 0, 4'b1011, 1'b0, 4'hF};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1010, 1'b0, 4'hF};
        vecs[25] = '{1'b1, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1010, 1'b0, 4'hF};
        vecs[26] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1110, 1'b0, 4'hF};
        vecs[27] = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 0, 4'b1111, 1'b0, 4'hE};
        vecs[28] = '{1'b0, 1'b0, 1'b1, 4'b0010, 16'h00D0, 1, 4'b1111, 1'b0, 4'h4};
        vecs[29] = '{1'b0, 1'b0, 1'b0, 4'b1101, 16'h8605, 0, 4'b1111, 1'b1, 4'h0};
        vecs[30] = '{1'b0, 1'b1, 1'b0, 4'b0010, 16'h0090, 0, 4'b0010, 1'b0, 4'hD};

        reset = 1'b1;
        idle(99);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_no_output", 32'(cdb_no_output), 32'd1);
        chk("rst_tag", 32'(cdb_tag), 32'd0);
        chk("rst_tag_valid", 32'(cdb_tag_valid), 32'd0);
        chk("rst_value", cdb_value, 32'd0);
        chk("rst_take_branch", 32'(cdb_take_branch), 32'd0);
        chk("rst_ready", 32'(fu_ready), 32'hF);
        reset = 1'b0;

        for (int n = 0; n < 31; n++) begin
            @(posedge clock);
            #1;
            drive(n, vecs[n].st, vecs[n].sq, vecs[n].pu, vecs[n].val, vecs[n].tags, vecs[n].start);
            #1;
            chk($sformatf("v%0d_ready", n), 32'(fu_ready), 32'(vecs[n].rdy));
            chk($sformatf("v%0d_no_output", n), 32'(cdb_no_output), 32'(vecs[n].no));
            if (!vecs[n].no)
                chk($sformatf("v%0d_tag", n), 32'(cdb_tag), 32'(vecs[n].et));
        end

        // Cycle after the squash: everything flushed and the old branch flag dropped.
        @(posedge clock);
        #1;
        idle(31);
        #1;
        chk("sq_no_output", 32'(cdb_no_output), 32'd1);
        chk("sq_take_branch", 32'(cdb_take_branch), 32'd0);
        chk("sq_tag_valid", 32'(cdb_tag_valid), 32'd0);
        chk("sq_ready", 32'(fu_ready), 32'hF);
        repeat (3) begin
            @(posedge clock);
            #1;
            idle(32);
        end

        // Reset mid-run with three buffers loaded and the CDB active.
        @(posedge clock);
        #1;
        drive(40, 1'b0, 1'b0, 1'b0, 4'b0111, 16'h0321, 0);
        exp_q.push_back('{fu_tag[2], fu_value[2], fu_has_dest[2], fu_take_branch[2]});
        @(posedge clock);
        #1;
        idle(41);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(42);
        #1;
        chk("pre_rst_no_output", 32'(cdb_no_output), 32'd0);
        chk("pre_rst_tag", 32'(cdb_tag), 32'd3);
        @(posedge clock);
        #1;
        chk("mid_rst_no_output", 32'(cdb_no_output), 32'd1);
        chk("mid_rst_tag", 32'(cdb_tag), 32'd0);
        chk("mid_rst_tag_valid", 32'(cdb_tag_valid), 32'd0);
        chk("mid_rst_value", cdb_value, 32'd0);
        chk("mid_rst_take_branch", 32'(cdb_take_branch), 32'd0);
        chk("mid_rst_ready", 32'(fu_ready), 32'hF);
        reset = 1'b0;
        // Pointer back at 0 means FU1 beats FU3.
        drive(43, 1'b0, 1'b0, 1'b1, 4'b1010, 16'h7050, 0);
        repeat (5) begin
            @(posedge clock);
            #1;
            idle(44);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
